response_router: RTL

Return-path companion to the interconnect's GPU-priority arbiter. It records the requester ID of every request accepted by shared memory in an in-order tag FIFO. When memory returns the response data, it pops the oldest ID and steers the response to that requester through a one-entry output register with per-requester valid/ready. It sits between the memory response port and the CPU (ID 0) and GPU units (IDs 1..NUM_REQUESTERS-1). Its `tag_full` output gates the arbiter's grant.

---
 rtl/response_router.sv | 139 +++++++++++++
 1 files changed

// File: rtl/response_router.sv
// Return-path router: in-order tag FIFO of requester IDs plus a
// one-entry output register steering memory responses to requesters.
module response_router #(
    parameter int NUM_REQUESTERS = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 8,
    parameter int ID_W           = $clog2(NUM_REQUESTERS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_fire,
    input  logic [ID_W-1:0]            req_id,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]      mem_rsp_data,
    output logic                       mem_rsp_ready,
    output logic [NUM_REQUESTERS-1:0]  rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    input  logic [NUM_REQUESTERS-1:0]  rsp_ready,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       tag_full,
    output logic                       tag_empty,
    output logic                       err_overflow,
    output logic                       err_orphan,
    output logic                       err_bad_id
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [ID_W:0] NR = (ID_W + 1)'(NUM_REQUESTERS);

    logic [ID_W-1:0]       r_tags [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_out_valid;
    logic [ID_W-1:0]       r_out_id;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_err_overflow;
    logic                  r_err_orphan;
    logic                  r_err_bad_id;

    logic                      w_empty;
    logic                      w_full;
    logic                      w_id_ok;
    logic                      w_sel_ready;
    logic [NUM_REQUESTERS-1:0] w_onehot;
    logic                      w_deliver;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_pop;
    logic                      w_orphan;
    logic                      w_push;
    logic                      w_overflow;
    logic                      w_bad_clear;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_id_ok = ({1'b0, r_out_id} < NR);

    // Decode the held ID without indexing past the ready/valid vectors.
    always_comb begin
        w_onehot    = '0;
        w_sel_ready = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (r_out_id == ID_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_sel_ready = rsp_ready[i];
            end
        end
    end

    assign w_deliver   = r_out_valid && w_sel_ready;
    assign w_ready     = w_empty || !r_out_valid || w_deliver;
    assign w_accept    = mem_rsp_valid && w_ready;
    assign w_pop       = w_accept && !w_empty;
    assign w_orphan    = w_accept && w_empty;
    assign w_push      = req_fire && (!w_full || w_pop);
    assign w_overflow  = req_fire && w_full && !w_pop;
    assign w_bad_clear = r_out_valid && !w_id_ok;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wptr] <= req_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_out_valid    <= 1'b0;
            r_out_id       <= '0;
            r_out_data     <= '0;
            r_err_overflow <= 1'b0;
            r_err_orphan   <= 1'b0;
            r_err_bad_id   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            // A new load takes priority over freeing the slot.
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_id    <= r_tags[r_rptr];
                r_out_data  <= mem_rsp_data;
            end else if (w_deliver || w_bad_clear) begin
                r_out_valid <= 1'b0;
            end
            if (w_overflow) begin
                r_err_overflow <= 1'b1;
            end
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
            if (w_bad_clear) begin
                r_err_bad_id <= 1'b1;
            end
        end
    end

    assign mem_rsp_ready = w_ready;
    assign rsp_valid     = (r_out_valid && w_id_ok) ? w_onehot : '0;
    assign rsp_data      = r_out_data;
    assign outstanding   = r_count;
    assign tag_full      = w_full;
    assign tag_empty     = w_empty;
    assign err_overflow  = r_err_overflow;
    assign err_orphan    = r_err_orphan;
    assign err_bad_id    = r_err_bad_id;

endmodule
